// File: rtl/hw2_pkg.sv
// Shared definitions for the hw2 (a+/-b)*c datapath and its result buffer.
package hw2_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] hw2_result_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hw2_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module hw2_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [hw2_pkg::clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]                wdata,
  input  logic [hw2_pkg::clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]                rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; validity is tracked by the buffer's level.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hw2_result_buf.sv
// Result buffer: valid/ready FWFT FIFO for datapath results plus a running sum with sticky overflow.
module hw2_result_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int ACC_W  = 24
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic [hw2_pkg::clog2(DEPTH):0]   level,
  input  logic                             acc_clr,
  output logic [ACC_W-1:0]                 acc_sum,
  output logic                             acc_ovf
);

  import hw2_pkg::*;

  localparam int PTR_W = clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [ACC_W-1:0] acc_sum_r;
  logic             acc_ovf_r;

  logic             push;
  logic             pop;
  logic [ACC_W:0]   acc_add;
  logic [ACC_W-1:0] acc_sum_nxt;
  logic             acc_ovf_nxt;

  // in_ready depends only on registered level, never on out_ready.
  assign in_ready  = rst_n & (level_r != LVL_W'(DEPTH));
  assign out_valid = (level_r != LVL_W'(0));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign level     = level_r;
  assign acc_sum   = acc_sum_r;
  assign acc_ovf   = acc_ovf_r;

  hw2_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_r),
    .wdata (in_data),
    .raddr (rd_ptr_r),
    .rdata (out_data)
  );

  assign acc_add = {1'b0, acc_sum_r} + (ACC_W + 1)'(in_data);

  // Clear wins over accumulation; a push in the clear cycle seeds the sum.
  always_comb begin
    acc_sum_nxt = acc_sum_r;
    acc_ovf_nxt = acc_ovf_r;
    case ({acc_clr, push})
      2'b11: begin
        acc_sum_nxt = ACC_W'(in_data);
        acc_ovf_nxt = 1'b0;
      end
      2'b10: begin
        acc_sum_nxt = '0;
        acc_ovf_nxt = 1'b0;
      end
      2'b01: begin
        acc_sum_nxt = acc_add[ACC_W-1:0];
        acc_ovf_nxt = acc_ovf_r | acc_add[ACC_W];
      end
      default: begin
        acc_sum_nxt = acc_sum_r;
        acc_ovf_nxt = acc_ovf_r;
      end
    endcase
  end

  // Pointer, occupancy and accumulator state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r  <= '0;
      wr_ptr_r  <= '0;
      level_r   <= '0;
      acc_sum_r <= '0;
      acc_ovf_r <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
      acc_sum_r <= acc_sum_nxt;
      acc_ovf_r <= acc_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_hw2_result_buf.sv
// Directed bench for hw2_result_buf: fill/drain, streaming order, accumulator wrap and clears.
module tb_hw2_result_buf;

  import hw2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  hw2_result_t in_data;
  logic        out_valid;
  logic        out_ready;
  hw2_result_t out_data;
  logic [2:0]  level;
  logic        acc_clr;
  logic [23:0] acc_sum;
  logic        acc_ovf;

  int total = 0;
  int bad   = 0;

  hw2_result_buf #(.DATA_W(16), .DEPTH(4), .ACC_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .acc_clr   (acc_clr),
    .acc_sum   (acc_sum),
    .acc_ovf   (acc_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  hw2_result_t fill_vec [4];
  hw2_result_t q [$];
  logic [23:0] model_sum;
  logic [15:0] ra, rb, rc, rd;
  hw2_result_t prev;

  initial begin
    fill_vec[0] = 16'h0033; fill_vec[1] = 16'h0021;
    fill_vec[2] = 16'h0000; fill_vec[3] = 16'hFFF1;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
    out_ready = 1'b0; acc_clr = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();

    // 1. reset/idle state, and in_ready forced low during reset
    check("idle_level", level, 32'd0);
    check("idle_out_valid", out_valid, 32'd0);
    check("idle_in_ready", in_ready, 32'd1);
    check("idle_acc_sum", acc_sum, 32'd0);
    check("idle_acc_ovf", acc_ovf, 32'd0);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 16'hABCD;
    #1;
    check("rst_in_ready", in_ready, 32'd0);
    step();
    check("rst_no_store", level, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();

    // 2. fill to full with consumer stalled
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = fill_vec[i];
      step();
    end
    in_valid = 1'b0;
    check("full_level", level, 32'd4);
    check("full_in_ready", in_ready, 32'd0);
    check("full_out_data", out_data, 32'h0033);
    check("full_acc_sum", acc_sum, 32'h010045);
    step();
    check("full_hold_data", out_data, 32'h0033);

    // 3. full with push attempt and pop: pop only
    in_valid = 1'b1; in_data = 16'h5555; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("fullpop_level", level, 32'd3);
    check("fullpop_in_ready", in_ready, 32'd1);
    check("fullpop_acc", acc_sum, 32'h010045);
    for (int i = 1; i < 4; i++) begin
      check("drain_valid", out_valid, 32'd1);
      check("drain_data", out_data, {16'h0000, fill_vec[i]});
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    check("drain_empty", out_valid, 32'd0);
    check("drain_level", level, 32'd0);

    // 4. steady stream of datapath results
    model_sum = 24'h010045;
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = (i % 2 == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
      rd = ($urandom_range(0, 1) == 1) ? 16'((ra + rb) * rc) : 16'((ra - rb) * rc);
      if (i > 0) begin
        check("stream_level", level, 32'd1);
        check("stream_order", out_data, {16'h0000, prev});
      end
      in_valid = 1'b1; out_ready = 1'b1; in_data = rd;
      model_sum = model_sum + {8'h00, rd};
      prev = rd;
      step();
    end
    in_valid = 1'b0;
    check("stream_last", out_data, {16'h0000, prev});
    step();
    out_ready = 1'b0;
    check("stream_empty", level, 32'd0);
    check("stream_sum", acc_sum, {8'h00, model_sum});

    // 5. accumulator wrap: clear, preload 0xFFFFF0, then add 0x0020
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    check("clr_sum", acc_sum, 32'd0);
    check("clr_ovf", acc_ovf, 32'd0);
    check("clr_level", level, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_valid = 1'b1;
      in_data = (i < 256) ? 16'hFFFF : 16'h00F0;
      step();
    end
    check("preload_sum", acc_sum, 32'hFFFFF0);
    check("preload_ovf", acc_ovf, 32'd0);
    in_data = 16'h0020;
    step();
    check("wrap_sum", acc_sum, 32'h000010);
    check("wrap_ovf", acc_ovf, 32'd1);
    in_data = 16'h0001;
    step();
    check("sticky_sum", acc_sum, 32'h000011);
    check("sticky_ovf", acc_ovf, 32'd1);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("acc_empty", level, 32'd0);
    check("pop_no_acc", acc_sum, 32'h000011);

    // 6. clear together with push, then reset with data buffered
    acc_clr = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
    step();
    acc_clr = 1'b0;
    check("clrpush_sum", acc_sum, 32'h001234);
    check("clrpush_ovf", acc_ovf, 32'd0);
    check("clrpush_level", level, 32'd1);
    check("clrpush_data", out_data, 32'h1234);
    in_data = 16'h0002;
    step();
    step();
    in_valid = 1'b0;
    check("pre_rst_level", level, 32'd3);
    check("pre_rst_sum", acc_sum, 32'h001238);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_level", level, 32'd0);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_acc_sum", acc_sum, 32'd0);
    step();
    check("post_rst_ready", in_ready, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
